lcd_pixel_out: RTL and testbench
================================

# lcd_pixel_out

Pixel-output stage directly downstream of the LCD timing generator. Takes that generator's raw sync/enable strobes plus image-window request and ROM address, forwards the address to the image ROM, realigns all sync signals with the returned ROM data, and drives the panel's RGB565 bus. Also generates built-in test patterns (colour bars, grid, solid background) for panel bring-up without image memory.

## Interface
Parameters:
- PIPE, 2, cycles from `img_ack_i` to the matching `rom_data` (1 for the address register in the timing generator + ROM read latency); legal 1..8
- BG_COLOR, 16'h0000, RGB565 colour outside the image window and in mode 2
- BAR_W, 100, colour-bar width in pixels; legal 1..2047
- GRID_COLOR, 16'hFFFF, RGB565 grid line colour in mode 3

Ports:
- clk  in  1  pixel clock, the same clock as the timing generator
- rest_n  in  1  synchronous reset, active-low
- mode  in  2  0 image, 1 colour bars, 2 solid BG_COLOR, 3 grid
- lcd_hsync_i  in  1  raw hsync, active-low
- lcd_vsync_i  in  1  raw vsync, active-low
- lcd_de_i  in  1  raw data enable
- img_ack_i  in  1  pixel inside the image window
- addr_i  in  16  image ROM address from the timing generator
- rom_addr  out  16  to image ROM; equals `addr_i` combinationally
- rom_data  in  16  RGB565 ROM output, valid PIPE cycles after the matching `img_ack_i`
- lcd_hsync  out  1  aligned hsync
- lcd_vsync  out  1  aligned vsync
- lcd_de  out  1  aligned data enable
- lcd_data  out  16  RGB565 pixel, {R[4:0],G[5:0],B[4:0]}
- frame_done  out  1  one-cycle pulse on the falling edge of the aligned vsync

## Operation
- Delay line: `lcd_hsync_i`, `lcd_vsync_i`, `lcd_de_i` and `img_ack_i` each pass through a PIPE-stage shift register (stage N = `*_d`).
- Output register: the `*_d` signals and the selected pixel are registered once more. All outputs are registered.
- Pixel select, evaluated on stage-PIPE values:
  - `de_d`=0: 16'h0000.
  - mode 0: `rom_data` if `ack_d`, else BG_COLOR.
  - mode 1: bar colour by bar index (order below).
  - mode 2: BG_COLOR.
  - mode 3: GRID_COLOR if `x_cnt[4:0]`==0 or `y_cnt[4:0]`==0, else BG_COLOR.
- Bar order, index 0..7: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. The index saturates at 7.
- `x_cnt` (11 bit): 0 on the first `de_d` cycle of a line, then +1 per `de_d` cycle. Held at 0 while `de_d`=0.
- Bar counter:
  - `bar_pos` counts 0..BAR_W-1 alongside `x_cnt`.
  - At BAR_W-1 it wraps to 0 and the bar index increments.
  - Both clear while `de_d`=0.
  - No divider.
- `y_cnt` (11 bit):
  - +1 on each falling edge of `de_d`.
  - Clears to 0 on the falling edge of `vsync_d`.
  - Wraps at 2047.
- Mode latch:
  - `mode` is sampled into `mode_q` only on the falling edge of `vsync_d`, and at reset.
  - A mid-frame change never tears a frame.
- `frame_done` fires on the same cycle `y_cnt` clears.

## Timing
- Latency: every input sampled at cycle t appears on the outputs at t+PIPE+1. `rom_data` is sampled at t+PIPE.
- `rom_addr`: zero latency, no register.
- Reset (synchronous, `rest_n`=0 at a rising edge):
  - Delay lines load idle values: syncs 1, de 0, ack 0.
  - Outputs: `lcd_hsync`=1, `lcd_vsync`=1, `lcd_de`=0, `lcd_data`=0, `frame_done`=0.
  - `x_cnt`, `y_cnt`, `bar_pos` and the bar index go to 0.
  - `mode_q` loads `mode`.
- After reset release, outputs show idle values for PIPE+1 cycles, then track the inputs.
- Reset mid-line or mid-frame: takes effect on the next edge with no partial pixel. Counters restart at 0.
- Simultaneous `de_d` falling edge and `vsync_d` falling edge: the clear wins, so `y_cnt`=0.
- `lcd_data` is 0 on every cycle where `lcd_de`=0, including the cycle `de` falls.
- `img_ack_i` high while `lcd_de_i` low: treated as background, output 0.

## Test plan
- Reset: hold `rest_n`=0 for 5 cycles with random inputs. Require `lcd_data`=0, `lcd_de`=0, syncs=1 and no `frame_done` throughout. After release, outputs stay idle for exactly 3 cycles (PIPE=2).
- Mode 0: image window at x 0..99 with a ROM model of latency 1 after `addr_i`, data=addr. Require pixel 0 of line 0 = 16'h0000 (address 0), pixel 5 of line 1 = 16'd105, pixel 100 = BG_COLOR, and `lcd_de` rising 3 cycles after `lcd_de_i`.
- Mode 1, BAR_W=100, 800-pixel line: require pixels 0–99 = FFFF, pixel 100 = FFE0, pixel 699 = 001F, pixels 700–799 = 0000. Require the same values on line 2, with no carry-over between lines.
- Mode 3: require `lcd_data`=GRID_COLOR at x=0/32/64 on every line, and on all pixels of lines 0 and 32. Require (x=1, y=1) = BG_COLOR.
- Mode switch 0→1 mid-frame at line 200: require the rest of the frame to stay mode 0. Bars appear from the first line after the next `lcd_vsync` fall, coincident with a single `frame_done` pulse.
- Reset asserted at pixel 400 of line 100 in mode 1: require the outputs to be idle on the next edge. After release and the next frame start, `y_cnt` counts from 0 and bars are correct.

Source files
------------

// File: rtl/lcd_pixel_out.sv
// Pixel-output stage behind the LCD timing generator: realigns sync strobes with
// image-ROM data and drives the RGB565 panel bus, with built-in test patterns.
module lcd_pixel_out #(
  parameter int unsigned PIPE       = 2,
  parameter logic [15:0] BG_COLOR   = 16'h0000,
  parameter int unsigned BAR_W      = 100,
  parameter logic [15:0] GRID_COLOR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rest_n,
  input  logic [1:0]  mode,
  input  logic        lcd_hsync_i,
  input  logic        lcd_vsync_i,
  input  logic        lcd_de_i,
  input  logic        img_ack_i,
  input  logic [15:0] addr_i,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic        lcd_de,
  output logic [15:0] lcd_data,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    MODE_IMAGE = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_GRID  = 2'd3
  } mode_e;

  localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);

  logic [PIPE-1:0] hs_sr, vs_sr, de_sr, ack_sr;
  logic            hs_d, vs_d, de_d, ack_d;
  logic [10:0]     x_cnt, y_cnt, bar_pos;
  logic [2:0]      bar_idx;
  mode_e           mode_q;
  logic            vs_fall, de_fall;
  logic [15:0]     bar_color, pix;

  assign rom_addr = addr_i;

  always_ff @(posedge clk) begin
    if (!rest_n) begin
      hs_sr  <= '1;
      vs_sr  <= '1;
      de_sr  <= '0;
      ack_sr <= '0;
    end else begin
      hs_sr[0]  <= lcd_hsync_i;
      vs_sr[0]  <= lcd_vsync_i;
      de_sr[0]  <= lcd_de_i;
      ack_sr[0] <= img_ack_i;
      for (int unsigned i = 1; i < PIPE; i++) begin
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
        de_sr[i]  <= de_sr[i-1];
        ack_sr[i] <= ack_sr[i-1];
      end
    end
  end

  assign hs_d  = hs_sr[PIPE-1];
  assign vs_d  = vs_sr[PIPE-1];
  assign de_d  = de_sr[PIPE-1];
  assign ack_d = ack_sr[PIPE-1];

  // The output registers hold the previous stage-PIPE values, so they double as edge detectors.
  assign vs_fall = lcd_vsync & ~vs_d;
  assign de_fall = lcd_de & ~de_d;

  always_ff @(posedge clk) begin
    if (!rest_n) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      bar_pos <= '0;
      bar_idx <= '0;
      mode_q  <= mode_e'(mode);
    end else begin
      x_cnt <= de_d ? x_cnt + 11'd1 : '0;
      if (!de_d) begin
        bar_pos <= '0;
        bar_idx <= '0;
      end else if (bar_pos == BAR_LAST) begin
        bar_pos <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + 11'd1;
      end
      if (vs_fall)      y_cnt <= '0;
      else if (de_fall) y_cnt <= y_cnt + 11'd1;
      if (vs_fall) mode_q <= mode_e'(mode);
    end
  end

  always_comb begin
    bar_color = 16'h0000;
    case (bar_idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  end

  always_comb begin
    pix = BG_COLOR;
    if (!de_d) begin
      pix = '0;
    end else begin
      unique case (mode_q)
        MODE_IMAGE: pix = ack_d ? rom_data : BG_COLOR;
        MODE_BARS:  pix = bar_color;
        MODE_SOLID: pix = BG_COLOR;
        MODE_GRID:  pix = (x_cnt[4:0] == 5'd0 || y_cnt[4:0] == 5'd0) ? GRID_COLOR : BG_COLOR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rest_n) begin
      lcd_hsync  <= 1'b1;
      lcd_vsync  <= 1'b1;
      lcd_de     <= 1'b0;
      lcd_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      lcd_hsync  <= hs_d;
      lcd_vsync  <= vs_d;
      lcd_de     <= de_d;
      lcd_data   <= pix;
      frame_done <= vs_fall;
    end
  end

endmodule

// File: tb/tb_lcd_pixel_out.sv
// Randomised frame-level stimulus for lcd_pixel_out, checked every cycle against
// a geometry-based pixel model plus a table of hand-computed pixel values.
module tb_lcd_pixel_out;

  localparam int unsigned PIPE  = 2;
  localparam int unsigned BAR_W = 100;
  localparam logic [15:0] BG    = 16'h18E3;
  localparam logic [15:0] GRID  = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rest_n;
  logic [1:0]  mode;
  logic        hs_i, vs_i, de_i, ack_i;
  logic [15:0] addr_i, nxt_addr, rom_addr, rom_data;
  logic        lcd_hsync, lcd_vsync, lcd_de, frame_done;
  logic [15:0] lcd_data;

  always #5 clk = ~clk;

  lcd_pixel_out #(.PIPE(PIPE), .BG_COLOR(BG), .BAR_W(BAR_W), .GRID_COLOR(GRID)) dut (
    .clk(clk), .rest_n(rest_n), .mode(mode),
    .lcd_hsync_i(hs_i), .lcd_vsync_i(vs_i), .lcd_de_i(de_i), .img_ack_i(ack_i),
    .addr_i(addr_i), .rom_addr(rom_addr), .rom_data(rom_data),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
    .lcd_data(lcd_data), .frame_done(frame_done)
  );

  // Timing-generator address register followed by a 1-cycle ROM returning its address.
  always @(posedge clk) begin
    addr_i   <= nxt_addr;
    rom_data <= rom_addr;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rst, hs, vs, de, fd, pin;
    logic [15:0] data, pinv;
  } exp_t;
  exp_t expq [8];

  typedef struct {
    int          ph, x, y;
    logic [15:0] v;
  } pin_t;
  pin_t pins [$];

  int   n_vec = 0, n_err = 0;
  logic prev_vs = 1'b1;
  logic [1:0] mode_req = 2'd0;

  function automatic logic [15:0] bar_of(input int idx);
    case (idx)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] exp_pix(input int fm, input int x, input int y,
                                          input logic win, input logic [15:0] a);
    int idx;
    case (fm)
      0: return win ? a : BG;
      1: begin
        idx = x / int'(BAR_W);
        if (idx > 7) idx = 7;
        return bar_of(idx);
      end
      2: return BG;
      default: return (x % 32 == 0 || y % 32 == 0) ? GRID : BG;
    endcase
  endfunction

  // One pixel-clock cycle of stimulus, recorded with what the panel must show PIPE+1 cycles later.
  task automatic step(input logic r, input logic hs, input logic vs, input logic de,
                      input logic ack, input logic [15:0] addr, input logic [15:0] pix,
                      input logic pin, input logic [15:0] pinv);
    exp_t e;
    @(negedge clk);
    rest_n = r; hs_i = hs; vs_i = vs; de_i = de; ack_i = ack;
    nxt_addr = addr; mode = mode_req;
    e.rst = !r; e.pin = pin & r; e.pinv = pinv;
    if (!r) begin
      e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.fd = 1'b0; e.data = 16'h0000;
      prev_vs = 1'b1;
    end else begin
      e.hs = hs; e.vs = vs; e.de = de;
      e.data = de ? pix : 16'h0000;
      e.fd = prev_vs & ~vs;
      prev_vs = vs;
    end
    expq[cyc % 8] = e;
  endtask

  task automatic rnd_step(input logic r);
    step(r, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
         1'($urandom_range(1)), 16'($urandom), 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic idle_step();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'($urandom_range(1)), 16'($urandom), 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic frame(input int w, input int nl, input int wx0, input int wx1, input int fm,
                       input int wig, input int sw_line, input int sw_mode, input int ph,
                       input int ab_line, input int ab_px);
    int ww;
    ww = wx1 - wx0 + 1;
    mode_req = 2'(fm);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'($urandom_range(1)), 16'($urandom), 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) idle_step();
    for (int y = 0; y < nl; y++) begin
      if (wig != 0 && y > 0 && $urandom_range(3) == 0) mode_req = 2'($urandom_range(3));
      if (y == sw_line) mode_req = 2'(sw_mode);
      for (int x = 0; x < w; x++) begin
        logic        win, pin;
        logic [15:0] a, pv;
        if (y == ab_line && x == ab_px) begin
          for (int k = 0; k < 3; k++) begin
            mode_req = 2'($urandom_range(3));
            rnd_step(1'b0);
          end
          return;
        end
        win = (x >= wx0 && x <= wx1);
        a   = win ? 16'(y * ww + x - wx0) : 16'($urandom);
        pin = 1'b0; pv = 16'h0000;
        foreach (pins[k])
          if (pins[k].ph == ph && pins[k].x == x && pins[k].y == y) begin
            pin = 1'b1; pv = pins[k].v;
          end
        step(1'b1, 1'b1, 1'b1, 1'b1, win, a, exp_pix(fm, x, y, win, a), pin, pv);
      end
      for (int b = 0; b < 8; b++)
        step(1'b1, !(b >= 2 && b < 6), 1'b1, 1'b0, 1'($urandom_range(1)), 16'($urandom),
             16'h0, 1'b0, 16'h0);
    end
  endtask

  initial begin : cmp
    exp_t        e;
    logic        idle;
    logic [19:0] want, got;
    forever begin
      @(posedge clk);
      #1;
      if (cyc >= 5) begin
        e    = expq[(cyc - 3) % 8];
        idle = expq[(cyc - 1) % 8].rst | expq[(cyc - 2) % 8].rst | e.rst;
        want = idle ? {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000} : {e.hs, e.vs, e.de, e.fd, e.data};
        got  = {lcd_hsync, lcd_vsync, lcd_de, frame_done, lcd_data};
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL outputs cyc=%0d: got hs=%b vs=%b de=%b fd=%b data=%h, want hs=%b vs=%b de=%b fd=%b data=%h",
                   cyc, got[19], got[18], got[17], got[16], got[15:0],
                   want[19], want[18], want[17], want[16], want[15:0]);
        end
        if (!idle && e.pin) begin
          n_vec++;
          if (lcd_data !== e.pinv) begin
            n_err++;
            $display("FAIL pixel_literal cyc=%0d: got %h, want %h", cyc, lcd_data, e.pinv);
          end
        end
      end
    end
  end

  initial begin
    logic [1:0] rm;
    rest_n = 1'b0; hs_i = 1'b1; vs_i = 1'b1; de_i = 1'b0; ack_i = 1'b0;
    nxt_addr = 16'h0000; mode = 2'd0;

    // image window x 0..99 of a 120-pixel line
    pins.push_back('{1, 0, 0, 16'h0000});
    pins.push_back('{1, 5, 1, 16'd105});
    pins.push_back('{1, 100, 0, BG});
    pins.push_back('{1, 99, 2, 16'd299});
    // colour bars on lines 0 and 2 of an 800-pixel line
    for (int ln = 0; ln <= 2; ln += 2) begin
      pins.push_back('{2, 0, ln, 16'hFFFF});
      pins.push_back('{2, 99, ln, 16'hFFFF});
      pins.push_back('{2, 100, ln, 16'hFFE0});
      pins.push_back('{2, 250, ln, 16'h07FF});
      pins.push_back('{2, 699, ln, 16'h001F});
      pins.push_back('{2, 700, ln, 16'h0000});
      pins.push_back('{2, 799, ln, 16'h0000});
    end
    // grid
    pins.push_back('{3, 0, 5, GRID});
    pins.push_back('{3, 32, 7, GRID});
    pins.push_back('{3, 64, 39, GRID});
    pins.push_back('{3, 17, 0, GRID});
    pins.push_back('{3, 50, 32, GRID});
    pins.push_back('{3, 1, 1, BG});
    pins.push_back('{3, 33, 33, BG});
    // mid-frame mode switch: frame stays image, next frame is bars
    pins.push_back('{4, 3, 204, 16'd8163});
    pins.push_back('{4, 0, 201, 16'd8040});
    pins.push_back('{5, 0, 0, 16'hFFFF});
    pins.push_back('{5, 39, 3, 16'hFFFF});
    // bars after a mid-frame reset
    pins.push_back('{7, 0, 1, 16'hFFFF});
    pins.push_back('{7, 550, 1, 16'hF800});
    pins.push_back('{7, 650, 0, 16'h001F});
    pins.push_back('{7, 799, 1, 16'h0000});

    for (int i = 0; i < 5; i++) begin
      mode_req = 2'($urandom_range(3));
      rnd_step(1'b0);
    end
    rm = mode_req;
    for (int x = 0; x < 4; x++)
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'($urandom), exp_pix(int'(rm), x, 0, 1'b0, 16'h0),
           1'b0, 16'h0);
    for (int i = 0; i < 8; i++) idle_step();

    frame(120, 3, 0, 99, 0, 0, -1, 0, 1, -1, -1);
    frame(800, 3, 0, 799, 1, 1, -1, 0, 2, -1, -1);
    frame(80, 40, 10, 50, 3, 1, -1, 0, 3, -1, -1);
    for (int f = 0; f < 4; f++) begin
      int w, lo, hi;
      w  = int'($urandom_range(60, 20));
      lo = int'($urandom_range(w - 1));
      hi = int'($urandom_range(w - 1, lo));
      frame(w, int'($urandom_range(8, 3)), lo, hi, int'($urandom_range(3)), 1, -1, 0, 0, -1, -1);
    end
    frame(40, 205, 0, 39, 0, 0, 200, 1, 4, -1, -1);
    frame(40, 4, 0, 39, 1, 0, -1, 0, 5, -1, -1);
    frame(410, 101, 0, 409, 1, 0, -1, 0, 6, 100, 400);
    for (int i = 0; i < 6; i++) idle_step();
    frame(800, 2, 0, 799, 1, 0, -1, 0, 7, -1, -1);
    for (int i = 0; i < 6; i++) idle_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
